clk_div_checker: RTL
====================

# clk_div_checker

Self-checking monitor that sits directly downstream of the clock-divider stage. It consumes the div2/div4/div8/div16 tap outputs as same-clock data, phase-locks an internal reference counter to them, then flags every cycle on which any tap departs from the ideal binary divide pattern. Results are a lock indication, a sticky error flag, a saturating error count and per-tap sticky fail bits, all suitable for routing to spare output pins.

## Interface

Parameters:
- NUM_TAPS, 4, number of divider taps; tap i divides by 2^(i+1).
- ERR_W, 4, width of the saturating error counter.
- LOCK_CYCLES, 32, consecutive matching cycles required before `locked` asserts (range 1..255).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  checking enable; low forces IDLE.
- clr  in  1  synchronous clear of err_flag, err_cnt, fail_tap.
- taps  in  NUM_TAPS  divider outputs, bit0 = div2 … bit3 = div16; generated by flops on the same clk.
- locked  out  1  reference counter aligned and verified.
- err_flag  out  1  sticky, set on any error.
- err_cnt  out  ERR_W  saturating error count.
- fail_tap  out  NUM_TAPS  sticky per-tap mismatch bits.

## Operation

- Input stage: `s <= taps` every cycle; `s_prev <= s`. All checks use `s`.
- Reference counter `ref` is NUM_TAPS bits and wraps modulo 2^NUM_TAPS.
- FSM states: IDLE, ACQUIRE, VERIFY, LOCKED.
  - IDLE: `locked=0`. If en=1, go to ACQUIRE and clear the timeout counter.
  - ACQUIRE: watch for a rising edge of the slowest tap (`s[N-1]=1`, `s_prev[N-1]=0`). On that edge, load `ref <= s + 1`, clear the match counter and go to VERIFY.
    - A timeout counter counts ACQUIRE cycles. On reaching 2^(NUM_TAPS+1) with no edge, log a stuck error with fail mask = bit N-1 only, reset the timeout and stay in ACQUIRE.
  - VERIFY: each cycle `ref <= ref + 1`.
    - If `s == ref`, increment the match counter; on reaching LOCKED_CYCLES go to LOCKED.
    - If `s != ref`, log an error with mask `s ^ ref` and go to ACQUIRE.
  - LOCKED: `locked=1`; `ref` keeps incrementing. A mismatch logs an error with mask `s ^ ref` and goes to ACQUIRE.
- en=0 in any state → IDLE next cycle. Sticky outputs hold.
- Logging an error:
  - err_flag <= 1
  - err_cnt <= err_cnt+1, saturating at 2^ERR_W−1 (no wrap)
  - fail_tap <= fail_tap | mask
- clr: zeroes err_flag, err_cnt and fail_tap. clr has priority over a same-cycle error, so that error is discarded. clr does not affect the FSM.

## Timing

- Reset (async, immediate): state=IDLE, locked=0, err_flag=0, err_cnt=0, fail_tap=0, ref=0, s=0, s_prev=0, all internal counters 0.
- Latency: a tap value present at edge k (captured into `s`) is compared in cycle k..k+1. Its effect on err_flag, err_cnt, fail_tap and locked is visible after edge k+1.
- `locked` deasserts after the same edge that logs the mismatch.
- Lock latency, ideal taps: at most 2^NUM_TAPS cycles to the first slowest-tap edge, plus 1 cycle, plus LOCK_CYCLES.
- Reset asserted mid-LOCKED: all outputs drop to 0 asynchronously; re-acquisition starts from IDLE after reset release.
- ref wrap-around (all ones → 0) is a normal match, never an error.

## Test plan

- Ideal taps from a free-running 4-bit counter, en=1: locked=1 within 50 cycles; over 1000 further cycles err_cnt=0, err_flag=0, fail_tap=0.
- While locked, invert taps[1] for one cycle: err_cnt=1, err_flag=1, fail_tap=4'b0010. locked drops for one or more cycles, then re-asserts within 50 cycles.
- Hold taps=0 with en=1 for 100 cycles: err_cnt=3 (timeouts at 32, 64, 96), fail_tap=4'b1000, locked=0 throughout.
- Inject 20 single-cycle glitches spaced more than 50 cycles apart: err_cnt saturates at 15, err_flag=1.
- Assert clr on the same cycle as a glitch: the next cycle shows err_cnt=0, err_flag=0, fail_tap=0. A later glitch gives err_cnt=1.
- Pulse rst_n low for 3 cycles while locked with err_cnt=5: all outputs are 0 during reset. After release, locked re-asserts within 50 cycles and err_cnt stays 0.

Source files
------------

// File: rtl/clk_div_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_checker_if
// Purpose  : Bundles the checker's control inputs, divider tap inputs and
//            status outputs.
// Ports    : en, clr, taps          - driven by the master (stimulus side)
//            locked, err_flag,
//            err_cnt, fail_tap      - driven by the slave (checker)
// Revision : 1.0 - initial release
// ============================================================================
interface clk_div_checker_if #(
  parameter int NUM_TAPS = 4,
  parameter int ERR_W    = 4
);
  logic                en;
  logic                clr;
  logic [NUM_TAPS-1:0] taps;
  logic                locked;
  logic                err_flag;
  logic [ERR_W-1:0]    err_cnt;
  logic [NUM_TAPS-1:0] fail_tap;

  modport master (
    output en, clr, taps,
    input  locked, err_flag, err_cnt, fail_tap
  );

  modport slave (
    input  en, clr, taps,
    output locked, err_flag, err_cnt, fail_tap
  );
endinterface
`default_nettype wire

// File: rtl/clk_div_checker.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_checker
// Purpose  : Monitors the div2/div4/.../div2^NUM_TAPS taps of a clock divider.
//            It phase-locks a reference counter to the taps and reports every
//            cycle on which the taps depart from an ideal binary count.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - slave side of clk_div_checker_if
//                     (en, clr, taps in; locked, err_flag, err_cnt,
//                      fail_tap out)
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_checker #(
  parameter int NUM_TAPS    = 4,
  parameter int ERR_W       = 4,
  parameter int LOCK_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  clk_div_checker_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_VERIFY  = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  // A timeout fires on the 2^(NUM_TAPS+1)-th acquire cycle without an edge.
  localparam logic [NUM_TAPS:0]   c_tmo_last   = '1;
  localparam logic [7:0]          c_match_last = 8'(LOCK_CYCLES - 1);
  localparam logic [NUM_TAPS-1:0] c_stuck_mask = NUM_TAPS'(1) << (NUM_TAPS - 1);
  localparam logic [NUM_TAPS-1:0] c_one        = NUM_TAPS'(1);
  localparam logic [ERR_W-1:0]    c_cnt_max    = '1;

  state_t              r_state;
  logic [NUM_TAPS-1:0] r_s;
  logic [NUM_TAPS-1:0] r_s_prev;
  logic [NUM_TAPS-1:0] r_ref;
  logic [NUM_TAPS:0]   r_tmo;
  logic [7:0]          r_match;
  logic                r_locked;
  logic                r_err_flag;
  logic [ERR_W-1:0]    r_err_cnt;
  logic [NUM_TAPS-1:0] r_fail_tap;

  logic                w_edge;
  logic                w_mismatch;
  logic                w_log_err;
  logic [NUM_TAPS-1:0] w_log_mask;

  // Input capture; all checks operate on the registered copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s      <= '0;
      r_s_prev <= '0;
    end else begin
      r_s      <= bus.taps;
      r_s_prev <= r_s;
    end
  end

  assign w_edge     = r_s[NUM_TAPS-1] & ~r_s_prev[NUM_TAPS-1];
  assign w_mismatch = (r_s != r_ref);

  // Error decision for the current cycle; nothing is checked while disabled.
  always_comb begin
    w_log_err  = 1'b0;
    w_log_mask = '0;
    if (bus.en) begin
      case (r_state)
        ST_ACQUIRE: begin
          if (!w_edge && (r_tmo == c_tmo_last)) begin
            w_log_err  = 1'b1;
            w_log_mask = c_stuck_mask;
          end
        end
        ST_VERIFY, ST_LOCKED: begin
          if (w_mismatch) begin
            w_log_err  = 1'b1;
            w_log_mask = r_s ^ r_ref;
          end
        end
        default: begin
          w_log_err  = 1'b0;
          w_log_mask = '0;
        end
      endcase
    end
  end

  // Lock FSM with registered lock indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ref    <= '0;
      r_tmo    <= '0;
      r_match  <= '0;
      r_locked <= 1'b0;
    end else if (!bus.en) begin
      r_state  <= ST_IDLE;
      r_locked <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_ACQUIRE;
          r_tmo   <= '0;
        end
        ST_ACQUIRE: begin
          if (w_edge) begin
            // The taps will read s+1 on the next cycle if they are healthy.
            r_ref   <= r_s + c_one;
            r_match <= '0;
            r_state <= ST_VERIFY;
          end else if (r_tmo == c_tmo_last) begin
            r_tmo <= '0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_VERIFY: begin
          r_ref <= r_ref + c_one;
          if (w_mismatch) begin
            r_state <= ST_ACQUIRE;
            r_tmo   <= '0;
          end else if (r_match == c_match_last) begin
            r_state  <= ST_LOCKED;
            r_locked <= 1'b1;
          end else begin
            r_match <= r_match + 1'b1;
          end
        end
        ST_LOCKED: begin
          r_ref <= r_ref + c_one;
          if (w_mismatch) begin
            r_state  <= ST_ACQUIRE;
            r_tmo    <= '0;
            r_locked <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error reporting; a clear wins over an error in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_flag <= 1'b0;
      r_err_cnt  <= '0;
      r_fail_tap <= '0;
    end else if (bus.clr) begin
      r_err_flag <= 1'b0;
      r_err_cnt  <= '0;
      r_fail_tap <= '0;
    end else if (w_log_err) begin
      r_err_flag <= 1'b1;
      if (r_err_cnt != c_cnt_max) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
      r_fail_tap <= r_fail_tap | w_log_mask;
    end
  end

  assign bus.locked   = r_locked;
  assign bus.err_flag = r_err_flag;
  assign bus.err_cnt  = r_err_cnt;
  assign bus.fail_tap = r_fail_tap;

endmodule
`default_nettype wire
